// File: rtl/ddr_dimm_bank_model.sv
// ddr_dimm_bank_model
//   Synthesizable DDR4 DIMM behavioural model for the controller test
//   environment. It decodes the DDR4 command pins and tracks one open row per
//   bank across BG x BA banks. Read and write bursts (BL8 and BC4) run at
//   runtime-programmable CL/CWL, and data lives in a small indexed array.
//   Data is abstracted to one beat per CK_t cycle.
// Ports
//   CK_t, reset_n                 clock (posedge), async active-low reset
//   cs_n, act_n, RAS/CAS/WE pins  DDR4 command pins
//   bg_addr, ba_addr, A[13:0]     bank group, bank, address (A12=BC_n, A10=AP)
//   dq_in / dq_out, dq_oe         write beat in; read beat out and read valid
//   rd_start, wr_end              read beat 0 marker; post-commit write pulse
//   bank_open                     per-bank open flags
//   cl_cur, cwl_cur               active read and write latencies
//   err[4:0]                      one-cycle error pulses
module ddr_dimm_bank_model #(
  parameter int unsigned BG_W      = 2,
  parameter int unsigned BA_W      = 2,
  parameter int unsigned ROW_W     = 17,
  parameter int unsigned COL_W     = 10,
  parameter int unsigned ROW_IDX_W = 4,
  parameter int unsigned DQ_W      = 8,
  parameter int unsigned MAX_LAT   = 24,
  parameter int unsigned CL_DEF    = 11,
  parameter int unsigned CWL_DEF   = 9
) (
  input  logic                      CK_t,
  input  logic                      reset_n,
  input  logic                      cs_n,
  input  logic                      act_n,
  input  logic                      RAS_n_A16,
  input  logic                      CAS_n_A15,
  input  logic                      WE_n_A14,
  input  logic [BG_W-1:0]           bg_addr,
  input  logic [BA_W-1:0]           ba_addr,
  input  logic [13:0]               A,
  input  logic [DQ_W-1:0]           dq_in,
  output logic [DQ_W-1:0]           dq_out,
  output logic                      dq_oe,
  output logic                      rd_start,
  output logic                      wr_end,
  output logic [2**(BG_W+BA_W)-1:0] bank_open,
  output logic [4:0]                cl_cur,
  output logic [4:0]                cwl_cur,
  output logic [4:0]                err
);
  localparam int unsigned BK_W  = BG_W + BA_W;
  localparam int unsigned NB    = 2**BK_W;
  localparam int unsigned IDX_W = BK_W + ROW_IDX_W + COL_W - 3;
  localparam int unsigned NW    = 2**IDX_W;

  typedef struct packed {
    logic             vld;
    logic             rw;    // 1 = write
    logic [IDX_W-1:0] idx;
    logic             bc4;
    logic             half;
  } ent_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} eng_t;

  logic [NB-1:0]    r_open;
  logic [ROW_W-1:0] r_row [NB];
  logic [4:0]       r_cl, r_cwl, r_err;
  ent_t             r_dl [MAX_LAT];
  eng_t             r_state, w_state_nxt;
  ent_t             r_cur;
  logic [2:0]       r_beat;
  logic [DQ_W-1:0]  r_wbuf [8];
  logic [DQ_W-1:0]  r_rbuf [8];
  logic [DQ_W-1:0]  r_mem [NW][8];
  logic [DQ_W-1:0]  r_dq_out;
  logic             r_dq_oe, r_rd_start, r_wr_end;

  // Command decode
  logic [BK_W-1:0]  w_bank;
  logic [2:0]       w_rcw;
  logic [16:0]      w_row_pins;
  logic [ROW_W-1:0] w_row_sel;
  logic [IDX_W-1:0] w_idx;
  logic [4:0]       w_lat, w_mrs_val, w_err;
  logic w_act, w_mrs, w_ref, w_pre, w_wr, w_rd, w_rw_cmd, w_bank_is_open;
  logic w_collide, w_push, w_dl_busy, w_mrs_cl, w_mrs_cwl, w_mrs_bad;
  ent_t w_new;
  ent_t w_dl_nxt [MAX_LAT];

  always_comb begin
    w_bank         = {bg_addr, ba_addr};
    w_rcw          = {RAS_n_A16, CAS_n_A15, WE_n_A14};
    w_row_pins     = {w_rcw, A};
    w_act          = ~cs_n & ~act_n;
    w_mrs          = ~cs_n & act_n & (w_rcw == 3'b000);
    w_ref          = ~cs_n & act_n & (w_rcw == 3'b001);
    w_pre          = ~cs_n & act_n & (w_rcw == 3'b010);
    w_wr           = ~cs_n & act_n & (w_rcw == 3'b100);
    w_rd           = ~cs_n & act_n & (w_rcw == 3'b101);
    w_rw_cmd       = w_wr | w_rd;
    w_bank_is_open = r_open[w_bank];
    w_row_sel      = r_row[w_bank];
    w_idx          = {w_bank, w_row_sel[ROW_IDX_W-1:0], A[COL_W-1:3]};
    w_lat          = w_wr ? r_cwl : r_cl;
    w_new.vld      = 1'b1;
    w_new.rw       = w_wr;
    w_new.idx      = w_idx;
    w_new.bc4      = ~A[12];
    w_new.half     = A[2];

    // An entry already one slot further out lands on the same due edge as
    // this command; the earlier-issued one keeps the slot.
    w_collide = 1'b0;
    w_dl_busy = 1'b0;
    for (int unsigned i = 0; i < MAX_LAT; i++) begin
      if (i != 0 && w_lat == 5'(i) && r_dl[i].vld) w_collide = 1'b1;
      w_dl_busy = w_dl_busy | r_dl[i].vld;
    end
    w_push = w_rw_cmd & w_bank_is_open & ~w_collide;

    for (int unsigned i = 0; i + 1 < MAX_LAT; i++) w_dl_nxt[i] = r_dl[i+1];
    w_dl_nxt[MAX_LAT-1] = '0;
    for (int unsigned i = 0; i < MAX_LAT; i++)
      if (w_push && w_lat == 5'(i + 1)) w_dl_nxt[i] = w_new;

    w_mrs_val = A[4:0];
    w_mrs_cl  = w_mrs & (ba_addr == BA_W'(0));
    w_mrs_cwl = w_mrs & (ba_addr == BA_W'(2));
    w_mrs_bad = (w_mrs_cl  & ((w_mrs_val < 5'd2) | (32'(w_mrs_val) > MAX_LAT)))
              | (w_mrs_cwl & ((w_mrs_val == 5'd0) | (32'(w_mrs_val) > MAX_LAT)))
              | (w_mrs & (w_dl_busy | (r_state != ST_IDLE)));
  end

  // Burst engine: output decode
  ent_t       w_due, w_e;
  logic [2:0] w_k, w_pos;
  logic w_start, w_busy_hit, w_active, w_last, w_is_wr, w_is_rd, w_commit;

  always_comb begin
    w_due      = r_dl[0];
    w_start    = w_due.vld & (r_state == ST_IDLE);
    w_busy_hit = w_due.vld & (r_state != ST_IDLE);
    w_active   = w_start | (r_state != ST_IDLE);
    w_e        = w_start ? w_due : r_cur;
    w_k        = w_start ? 3'd0 : r_beat;
    w_last     = w_active & (w_k == (w_e.bc4 ? 3'd3 : 3'd7));
    w_pos      = w_e.bc4 ? {w_e.half, w_k[1:0]} : w_k;
    w_is_wr    = w_active & w_e.rw;
    w_is_rd    = w_active & ~w_e.rw;
    w_commit   = w_is_wr & w_last;
  end

  // Burst engine: next state
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_active && !w_last) w_state_nxt = w_e.rw ? ST_WR : ST_RD;
  end

  always_comb begin
    w_err    = '0;
    w_err[0] = w_act & w_bank_is_open;
    w_err[1] = w_rw_cmd & ~w_bank_is_open;
    w_err[2] = (w_rw_cmd & w_bank_is_open & w_collide) | w_busy_hit;
    w_err[3] = w_ref & (|r_open);
    w_err[4] = w_mrs_bad;
  end

  // Burst engine: state register and all reset-bearing state
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_beat     <= '0;
      r_open     <= '0;
      r_cl       <= 5'(CL_DEF);
      r_cwl      <= 5'(CWL_DEF);
      r_err      <= '0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_rd_start <= 1'b0;
      r_wr_end   <= 1'b0;
      for (int unsigned i = 0; i < NB; i++) r_row[i] <= '0;
      for (int unsigned i = 0; i < MAX_LAT; i++) r_dl[i] <= '0;
      for (int unsigned b = 0; b < 8; b++) begin
        r_wbuf[b] <= '0;
        r_rbuf[b] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      for (int unsigned i = 0; i < MAX_LAT; i++) r_dl[i] <= w_dl_nxt[i];
      if (w_start) r_cur <= w_due;
      r_beat <= w_active ? w_k + 3'd1 : 3'd0;
      if (w_is_wr) r_wbuf[w_pos] <= dq_in;

      // Reads are fetched whole at beat 0. A commit can never share that
      // edge: it would be the last beat of a burst still holding the engine.
      r_dq_oe    <= w_is_rd;
      r_rd_start <= w_is_rd & w_start;
      if (w_is_rd) begin
        if (w_start) begin
          for (int unsigned b = 0; b < 8; b++) r_rbuf[b] <= r_mem[w_e.idx][b];
          r_dq_out <= r_mem[w_e.idx][w_pos];
        end else begin
          r_dq_out <= r_rbuf[w_pos];
        end
      end
      r_wr_end <= w_commit;
      r_err    <= w_err;

      if (w_act && !w_bank_is_open) begin
        r_open[w_bank] <= 1'b1;
        r_row[w_bank]  <= w_row_pins[ROW_W-1:0];
      end
      if (w_pre) begin
        if (A[10]) r_open <= '0;
        else       r_open[w_bank] <= 1'b0;
      end
      if (w_rw_cmd && w_bank_is_open && A[10]) r_open[w_bank] <= 1'b0;

      if (!w_mrs_bad) begin
        if (w_mrs_cl)  r_cl  <= w_mrs_val;
        if (w_mrs_cwl) r_cwl <= w_mrs_val;
      end
    end
  end

  // Storage has no reset; BC4 commits touch only their half of the word.
  always_ff @(posedge CK_t) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < 8; b++)
        if (!w_e.bc4 || ((b >= 4) == w_e.half))
          r_mem[w_e.idx][b] <= (3'(b) == w_pos) ? dq_in : r_wbuf[b];
    end
  end

  logic w_unused;
  assign w_unused = ^{w_row_sel, w_e.vld};

  assign dq_out    = r_dq_out;
  assign dq_oe     = r_dq_oe;
  assign rd_start  = r_rd_start;
  assign wr_end    = r_wr_end;
  assign bank_open = r_open;
  assign cl_cur    = r_cl;
  assign cwl_cur   = r_cwl;
  assign err       = r_err;
endmodule

// File: doc/ddr_dimm_bank_model.md
Name: ddr_dimm_bank_model

Overview:
- Synthesizable, parametrised DDR4 DIMM behavioural model for the controller test environment; successor to the single-burst DIMM model.
- Decodes the DDR4 command pins and tracks one open row per bank over BG×BA banks.
- Schedules read and write bursts at runtime-programmable CL/CWL with BL8 and BC4 support, and stores data in a small indexed array.
- Sits on the DIMM side of ddr_interface, opposite the controller. Data is abstracted to one beat per CK_t cycle.

Parameters:
- BG_W, 2, bank-group address width
- BA_W, 2, bank address width; NB = 2**(BG_W+BA_W) banks
- ROW_W, 17, row address width (max 17)
- COL_W, 10, column address width
- ROW_IDX_W, 4, number of row LSBs used in the storage index
- DQ_W, 8, data beat width
- MAX_LAT, 24, maximum CL/CWL; this is the delay-line depth
- CL_DEF, 11, CL after reset
- CWL_DEF, 9, CWL after reset

Ports:
- CK_t  in  1  clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14  in  1 each  command pins
- bg_addr  in  BG_W  bank group
- ba_addr  in  BA_W  bank
- A  in  14  A13..A0; A12 = BC_n, A10 = AP
- dq_in  in  DQ_W  write data beat
- dq_out  out  DQ_W  read data beat
- dq_oe  out  1  read data valid
- rd_start  out  1  high with read beat 0
- wr_end  out  1  one-cycle pulse after the last write beat commits
- bank_open  out  NB  per-bank open flag
- cl_cur, cwl_cur  out  5 each  active latencies
- err  out  5  one-cycle pulses: [0] ACT to open bank, [1] RD/WR to closed bank, [2] burst collision, [3] REF with a bank open, [4] illegal or busy MRS

Behaviour:
- Reset (async): bank_open=0, all open rows=0, delay line and burst engine empty, dq_out=0, dq_oe=0, rd_start=0, wr_end=0, err=0, cl_cur=CL_DEF, cwl_cur=CWL_DEF. Storage contents are undefined. Reset mid-burst aborts the burst with no commit.
- Decode at posedge, valid only when cs_n=0:
  - act_n=0 → ACT; row = {RAS_n_A16,CAS_n_A15,WE_n_A14,A}[ROW_W-1:0].
  - Otherwise, {RAS,CAS,WE}: 000 MRS, 001 REF, 010 PRE, 100 WR, 101 RD, 111 NOP; other codes are ignored.
  - cs_n=1 → NOP.
- Bank = {bg_addr,ba_addr}.
- ACT on a closed bank opens it and latches the row. ACT on an open bank → err[0]; state unchanged.
- PRE closes the addressed bank; with A10=1 it closes all banks. PRE on a closed bank is legal and silent.
- RD/WR on a closed bank → err[1] and the command is dropped. Otherwise the model pushes {rw, index, bc4=~A12, half=A[2]} into the delay line. index = {bank, row[ROW_IDX_W-1:0], col[COL_W-1:3]}.
- A10=1 on RD/WR (auto-precharge) closes the bank at the command edge.
- REF with any bank open → err[3]; otherwise it is a no-op.
- MRS:
  - ba=0 loads CL from A[4:0]; legal range 2..MAX_LAT.
  - ba=2 loads CWL from A[4:0]; legal range 1..MAX_LAT.
  - Out-of-range value, or MRS issued while the delay line or burst engine is non-empty → err[4]; the value is ignored.
- Burst timing: for a command sampled at edge E0, burst beat 0 occurs at edge E0+L, with L = cl_cur for reads and cwl_cur for writes.
- Burst length: BL8 = 8 beats (k=0..7); BC4 = 4 beats, mapped to storage beats 4*half+k.
- Write burst:
  - dq_in for beat k is sampled at edge E0+L+k.
  - The word commits at the last beat edge. BC4 updates only its half; the other four beats keep their stored values.
  - wr_end is high for the cycle after the commit.
- Read burst:
  - The word is fetched at edge E0+L. A write committed at that same edge must be visible (bypass).
  - dq_out = beat k and dq_oe=1 during the cycle after edge E0+L+k.
  - rd_start=1 with beat 0.
  - dq_out holds its last value when dq_oe=0.
- The burst engine handles one burst at a time:
  - A start on the edge after the previous last beat is seamless, with no gap.
  - A start while the engine is busy → err[2] and the new burst is dropped.
  - Two bursts due at the same edge: the one with the larger latency (earlier issued) wins; the other is dropped with err[2].
- Storage has 2**(BG_W+BA_W+ROW_IDX_W+COL_W-3) words of 8*DQ_W bits. Higher row bits alias.

Test Plan:
- Reset, then ACT bank 5 row 0x1A3, WR col 0x08 BL8 with dq_in 0x11..0x88 at CWL=9, then RD col 0x08 → dq_oe asserted 11 cycles after RD with beats 0x11..0x88; rd_start on beat 0; wr_end one cycle after beat 7.
- BC4 write with A[2]=1, data 0xA0..0xA3, over an existing BL8 word 0x00..0x07 → BL8 read returns 0x00,01,02,03,A0,A1,A2,A3.
- Two BL8 reads issued 8 cycles apart → 16 contiguous dq_oe cycles. Reads issued 4 cycles apart → err[2], second burst absent.
- MRS ba=0 A=5'd30 → err[4], cl_cur stays 11. MRS ba=0 A=5'd14 → subsequent read data appears 14 cycles later.
- ACT to an open bank → err[0]. RD to a precharged bank → err[1] with no dq_oe. RD with A10=1 → bank_open bit clears at the command edge. REF then → no error.
- reset_n low during write beat 3 → no commit; the word reads back with its pre-write value after re-ACT.
